// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter: round-robin arbiter that merges NUM_CH SRAM-style request
// channels onto one downstream bus and routes responses back in order.
// Responses are tracked in a small FIFO of {channel id, drop} entries.
module sram_req_arbiter #(
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int OUTST   = 2,
  localparam int WSTRB_W = DATA_W / 8,
  localparam int ID_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [NUM_CH-1:0]           ch_req,
  input  logic [NUM_CH-1:0]           ch_wr,
  input  logic [2*NUM_CH-1:0]         ch_size,
  input  logic [WSTRB_W*NUM_CH-1:0]   ch_wstrb,
  input  logic [ADDR_W*NUM_CH-1:0]    ch_addr,
  input  logic [DATA_W*NUM_CH-1:0]    ch_wdata,
  input  logic [NUM_CH-1:0]           ch_cancel,
  output logic [NUM_CH-1:0]           ch_addr_ok,
  output logic [NUM_CH-1:0]           ch_data_ok,
  output logic [DATA_W-1:0]           ch_rdata,
  output logic                        bus_req,
  output logic                        bus_wr,
  output logic [1:0]                  bus_size,
  output logic [WSTRB_W-1:0]          bus_wstrb,
  output logic [ADDR_W-1:0]           bus_addr,
  output logic [DATA_W-1:0]           bus_wdata,
  input  logic                        bus_addr_ok,
  input  logic                        bus_data_ok,
  input  logic [DATA_W-1:0]           bus_rdata,
  output logic                        proto_err
);

  localparam int PTR_W = (OUTST > 1) ? $clog2(OUTST) : 1;
  localparam int CNT_W = $clog2(OUTST + 1);

  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic               lock_q, lock_d;
  logic [ID_W-1:0]    lock_ch_q, lock_ch_d;
  logic               lock_wr_q, lock_wr_d;
  logic [1:0]         lock_size_q, lock_size_d;
  logic [WSTRB_W-1:0] lock_wstrb_q, lock_wstrb_d;
  logic [ADDR_W-1:0]  lock_addr_q, lock_addr_d;
  logic [DATA_W-1:0]  lock_wdata_q, lock_wdata_d;

  logic [ID_W-1:0]    fifo_id_q   [OUTST];
  logic [ID_W-1:0]    fifo_id_d   [OUTST];
  logic               fifo_drop_q [OUTST];
  logic               fifo_drop_d [OUTST];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               proto_err_q, proto_err_d;

  logic [ID_W-1:0]    rr_grant, grant;
  logic               rr_found, full, empty, accept, pop;
  logic [ID_W-1:0]    head_id;
  logic               head_drop;

  // Round-robin search: first requesting channel at or after rr_ptr.
  always_comb begin
    int idx;
    rr_grant = rr_ptr_q;
    rr_found = 1'b0;
    idx      = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!rr_found && ch_req[idx]) begin
        rr_found = 1'b1;
        rr_grant = ID_W'(idx);
      end
    end
  end

  // Bus request mux; a locked request replays the fields captured when it stalled.
  always_comb begin
    grant   = lock_q ? lock_ch_q : rr_grant;
    full    = (count_q == CNT_W'(OUTST));
    empty   = (count_q == '0);
    bus_req = resetn & ~full & (lock_q | rr_found);
    if (lock_q) begin
      bus_wr    = lock_wr_q;
      bus_size  = lock_size_q;
      bus_wstrb = lock_wstrb_q;
      bus_addr  = lock_addr_q;
      bus_wdata = lock_wdata_q;
    end else begin
      bus_wr    = ch_wr[grant];
      bus_size  = ch_size[int'(grant)*2 +: 2];
      bus_wstrb = ch_wstrb[int'(grant)*WSTRB_W +: WSTRB_W];
      bus_addr  = ch_addr[int'(grant)*ADDR_W +: ADDR_W];
      bus_wdata = ch_wdata[int'(grant)*DATA_W +: DATA_W];
    end
    accept     = bus_req & bus_addr_ok;
    ch_addr_ok = accept ? (NUM_CH'(1) << grant) : '0;
  end

  // Response path: head of the FIFO steers bus_data_ok back to its channel.
  always_comb begin
    head_id    = fifo_id_q[rd_ptr_q];
    head_drop  = fifo_drop_q[rd_ptr_q];
    pop        = resetn & bus_data_ok & ~empty;
    ch_data_ok = (pop & ~head_drop) ? (NUM_CH'(1) << head_id) : '0;
    ch_rdata   = bus_rdata;
    proto_err  = proto_err_q;
  end

  // Next-state: round-robin pointer, grant lock, response FIFO, error flag.
  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    lock_d       = lock_q;
    lock_ch_d    = lock_ch_q;
    lock_wr_d    = lock_wr_q;
    lock_size_d  = lock_size_q;
    lock_wstrb_d = lock_wstrb_q;
    lock_addr_d  = lock_addr_q;
    lock_wdata_d = lock_wdata_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    proto_err_d  = proto_err_q | (bus_data_ok & empty);

    if (accept) begin
      lock_d   = 1'b0;
      rr_ptr_d = (grant == ID_W'(NUM_CH - 1)) ? '0 : grant + ID_W'(1);
    end else if (bus_req && !lock_q) begin
      lock_d       = 1'b1;
      lock_ch_d    = grant;
      lock_wr_d    = bus_wr;
      lock_size_d  = bus_size;
      lock_wstrb_d = bus_wstrb;
      lock_addr_d  = bus_addr;
      lock_wdata_d = bus_wdata;
    end

    // Cancel marks every queued entry of that channel, then the push (if any)
    // lands with its own cancel bit so a same-cycle cancel is not missed.
    for (int i = 0; i < OUTST; i++) begin
      fifo_id_d[i]   = fifo_id_q[i];
      fifo_drop_d[i] = fifo_drop_q[i] | ch_cancel[fifo_id_q[i]];
    end
    if (accept) begin
      fifo_id_d[wr_ptr_q]   = grant;
      fifo_drop_d[wr_ptr_q] = ch_cancel[grant];
      wr_ptr_d = (wr_ptr_q == PTR_W'(OUTST - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(OUTST - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    if (accept && !pop) count_d = count_q + CNT_W'(1);
    else if (pop && !accept) count_d = count_q - CNT_W'(1);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rr_ptr_q     <= '0;
      lock_q       <= 1'b0;
      lock_ch_q    <= '0;
      lock_wr_q    <= 1'b0;
      lock_size_q  <= '0;
      lock_wstrb_q <= '0;
      lock_addr_q  <= '0;
      lock_wdata_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      proto_err_q  <= 1'b0;
      for (int i = 0; i < OUTST; i++) begin
        fifo_id_q[i]   <= '0;
        fifo_drop_q[i] <= 1'b0;
      end
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      lock_q       <= lock_d;
      lock_ch_q    <= lock_ch_d;
      lock_wr_q    <= lock_wr_d;
      lock_size_q  <= lock_size_d;
      lock_wstrb_q <= lock_wstrb_d;
      lock_addr_q  <= lock_addr_d;
      lock_wdata_q <= lock_wdata_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      proto_err_q  <= proto_err_d;
      for (int i = 0; i < OUTST; i++) begin
        fifo_id_q[i]   <= fifo_id_d[i];
        fifo_drop_q[i] <= fifo_drop_d[i];
      end
    end
  end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Testbench for sram_req_arbiter: directed scenarios followed by random
// traffic, all checked against a transaction-level reference model.
module tb_sram_req_arbiter;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int OS = 2;
  localparam int SW = DW / 8;

  logic            clk = 1'b0;
  logic            resetn;
  logic [N-1:0]    ch_req, ch_wr, ch_cancel;
  logic [2*N-1:0]  ch_size;
  logic [SW*N-1:0] ch_wstrb;
  logic [AW*N-1:0] ch_addr;
  logic [DW*N-1:0] ch_wdata;
  logic [N-1:0]    ch_addr_ok, ch_data_ok;
  logic [DW-1:0]   ch_rdata;
  logic            bus_req, bus_wr;
  logic [1:0]      bus_size;
  logic [SW-1:0]   bus_wstrb;
  logic [AW-1:0]   bus_addr;
  logic [DW-1:0]   bus_wdata;
  logic            bus_addr_ok, bus_data_ok;
  logic [DW-1:0]   bus_rdata;
  logic            proto_err;

  sram_req_arbiter #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .OUTST(OS)) dut (
    .clk(clk), .resetn(resetn),
    .ch_req(ch_req), .ch_wr(ch_wr), .ch_size(ch_size), .ch_wstrb(ch_wstrb),
    .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_cancel(ch_cancel),
    .ch_addr_ok(ch_addr_ok), .ch_data_ok(ch_data_ok), .ch_rdata(ch_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_wstrb(bus_wstrb),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  // Reference model: pending responses as queues, plus lock snapshot.
  int          mq_id[$];
  bit          mq_drop[$];
  int          m_rr;
  bit          m_lock;
  int          m_lock_g;
  logic        m_lwr;
  logic [1:0]  m_lsize;
  logic [SW-1:0] m_lwstrb;
  logic [AW-1:0] m_laddr;
  logic [DW-1:0] m_lwdata;
  bit          m_proto;
  bit          e_req, e_acc;
  int          e_g;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq_id.delete();
    mq_drop.delete();
    m_rr = 0;
    m_lock = 0;
    m_proto = 0;
  endtask

  // Compare DUT outputs against the model for the inputs now applied.
  task automatic eval(input string tag);
    logic [N-1:0] exp_dok;
    bit found;
    #1;
    check({tag, "_rdata"}, ch_rdata, bus_rdata);
    if (!resetn) begin
      e_req = 0;
      e_acc = 0;
      check({tag, "_rst_req"}, bus_req, 0);
      check({tag, "_rst_aok"}, ch_addr_ok, 0);
      check({tag, "_rst_dok"}, ch_data_ok, 0);
      return;
    end
    check({tag, "_proto"}, proto_err, m_proto);
    found = 0;
    e_g = 0;
    if (m_lock) begin
      found = 1;
      e_g = m_lock_g;
    end else begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_rr + k) % N;
        if (!found && ch_req[c]) begin
          found = 1;
          e_g = c;
        end
      end
    end
    e_req = found && (mq_id.size() < OS);
    e_acc = e_req && bus_addr_ok;
    check({tag, "_req"}, bus_req, e_req);
    if (e_req) begin
      if (m_lock) begin
        check({tag, "_addr"}, bus_addr, m_laddr);
        check({tag, "_wr"}, bus_wr, m_lwr);
        check({tag, "_size"}, bus_size, m_lsize);
        check({tag, "_wstrb"}, bus_wstrb, m_lwstrb);
        check({tag, "_wdata"}, bus_wdata, m_lwdata);
      end else begin
        check({tag, "_addr"}, bus_addr, ch_addr[e_g*AW +: AW]);
        check({tag, "_wr"}, bus_wr, ch_wr[e_g]);
        check({tag, "_size"}, bus_size, ch_size[e_g*2 +: 2]);
        check({tag, "_wstrb"}, bus_wstrb, ch_wstrb[e_g*SW +: SW]);
        check({tag, "_wdata"}, bus_wdata, ch_wdata[e_g*DW +: DW]);
      end
    end
    check({tag, "_aok"}, ch_addr_ok, e_acc ? (N'(1) << e_g) : N'(0));
    exp_dok = '0;
    if (bus_data_ok && mq_id.size() > 0 && !mq_drop[0]) exp_dok = N'(1) << mq_id[0];
    check({tag, "_dok"}, ch_data_ok, exp_dok);
  endtask

  // Advance the model by one clock with the current inputs, then the DUT.
  task automatic tick();
    if (!resetn) begin
      model_reset();
    end else begin
      if (bus_data_ok) begin
        if (mq_id.size() == 0) m_proto = 1;
        else begin
          void'(mq_id.pop_front());
          void'(mq_drop.pop_front());
        end
      end
      foreach (mq_id[i]) if (ch_cancel[mq_id[i]]) mq_drop[i] = 1;
      if (e_acc) begin
        mq_id.push_back(e_g);
        mq_drop.push_back(ch_cancel[e_g]);
        m_lock = 0;
        m_rr = (e_g + 1) % N;
      end else if (e_req && !m_lock) begin
        m_lock   = 1;
        m_lock_g = e_g;
        m_lwr    = ch_wr[e_g];
        m_lsize  = ch_size[e_g*2 +: 2];
        m_lwstrb = ch_wstrb[e_g*SW +: SW];
        m_laddr  = ch_addr[e_g*AW +: AW];
        m_lwdata = ch_wdata[e_g*DW +: DW];
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    resetn = 0; ch_req = 0; ch_wr = 0; ch_cancel = 0; ch_size = 0;
    ch_wstrb = 0; ch_addr = 0; ch_wdata = 0;
    bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
    model_reset();
    @(negedge clk);
    eval("rst0"); tick();
    eval("rst1"); tick();
    resetn = 1;

    // Alternating grants with both channels requesting.
    ch_addr = {32'h0000_2000, 32'h0000_1000};
    ch_wdata = {32'hBBBB_0001, 32'hAAAA_0000};
    ch_wr = 2'b10; ch_size = 4'b0110; ch_wstrb = 8'hF3;
    ch_req = 2'b11; bus_addr_ok = 1;
    for (int k = 0; k < 4; k++) begin
      bus_data_ok = (k > 0);
      bus_rdata = $urandom;
      eval("s035");
      check("s035_grant", ch_addr_ok, (k % 2 == 0) ? 2'b01 : 2'b10);
      check("s035_baddr", bus_addr, (k % 2 == 0) ? 32'h1000 : 32'h2000);
      tick();
    end
    ch_req = 0; bus_data_ok = 1;
    eval("drain0"); tick();

    // Grant lock holds channel 1 despite channel 0 arriving.
    bus_data_ok = 0; bus_addr_ok = 0; ch_req = 2'b10;
    eval("s036a"); check("s036a_baddr", bus_addr, 32'h2000); tick();
    ch_req = 2'b11; ch_addr = {32'h0000_2FFF, 32'h0000_1000};
    eval("s036b"); check("s036b_baddr", bus_addr, 32'h2000);
    check("s036b_aok", ch_addr_ok, 2'b00); tick();
    bus_addr_ok = 1;
    eval("s036c"); check("s036c_aok", ch_addr_ok, 2'b10);
    check("s036c_baddr", bus_addr, 32'h2000); tick();

    // Outstanding limit: block while full, pop does not lift it the same cycle.
    ch_req = 2'b01;
    eval("s037a"); tick();
    ch_req = 2'b11;
    eval("s037b"); check("s037b_req", bus_req, 1'b0); tick();
    bus_data_ok = 1;
    eval("s037c"); check("s037c_req", bus_req, 1'b0);
    check("s037c_dok", ch_data_ok, 2'b10); tick();
    bus_data_ok = 0;
    eval("s037d"); check("s037d_req", bus_req, 1'b1); tick();
    ch_req = 0; bus_data_ok = 1;
    eval("drain1"); tick();
    eval("drain2"); tick();

    // Cancelled ch0 response is swallowed, ch1 still delivered.
    bus_data_ok = 0; ch_req = 2'b01; ch_wr = 2'b00;
    eval("s038a"); tick();
    ch_req = 0; ch_cancel = 2'b01;
    eval("s038b"); tick();
    ch_cancel = 0; bus_data_ok = 1;
    eval("s038c"); check("s038c_dok", ch_data_ok, 2'b00); tick();
    bus_data_ok = 0; ch_req = 2'b10;
    eval("s038d"); tick();
    ch_req = 0; bus_data_ok = 1; bus_rdata = 32'hABCD_1234;
    eval("s038e"); check("s038e_dok", ch_data_ok, 2'b10);
    check("s038e_rdata", ch_rdata, 32'hABCD_1234); tick();

    // Response with nothing outstanding flags a sticky protocol error.
    eval("s039a"); check("s039a_dok", ch_data_ok, 2'b00); tick();
    bus_data_ok = 0;
    eval("s039b"); check("s039b_proto", proto_err, 1'b1); tick();
    eval("s039c"); tick();
    eval("s039d"); check("s039d_proto", proto_err, 1'b1);

    // Reset with two outstanding abandons them and restarts arbitration at 0.
    ch_req = 2'b10;
    eval("s040a"); tick();
    ch_req = 2'b01;
    eval("s040b"); tick();
    resetn = 0; ch_req = 2'b11;
    eval("s040c"); tick();
    resetn = 1; ch_req = 0; bus_data_ok = 1;
    eval("s040d"); check("s040d_proto", proto_err, 1'b0);
    check("s040d_dok", ch_data_ok, 2'b00); tick();
    bus_data_ok = 0; ch_req = 2'b11; bus_addr_ok = 1;
    eval("s040e"); check("s040e_proto", proto_err, 1'b1);
    check("s040e_aok", ch_addr_ok, 2'b01); tick();
    resetn = 0; ch_req = 0;
    eval("s040f"); tick();
    resetn = 1;

    // Random traffic against the model.
    for (int cyc = 0; cyc < 800; cyc++) begin
      resetn      = ($urandom_range(0, 149) != 0);
      ch_req      = N'($urandom);
      ch_wr       = N'($urandom);
      ch_size     = (2*N)'($urandom);
      ch_wstrb    = (SW*N)'($urandom);
      ch_addr     = {$urandom, $urandom};
      ch_wdata    = {$urandom, $urandom};
      ch_cancel   = ($urandom_range(0, 7) == 0) ? N'($urandom) : N'(0);
      bus_addr_ok = 1'($urandom);
      if (mq_id.size() > 0) bus_data_ok = ($urandom_range(0, 2) == 0);
      else bus_data_ok = ($urandom_range(0, 59) == 0);
      bus_rdata   = $urandom;
      eval("rnd");
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
